// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one byte-wide UART transmitter between two word
//               requesters. Grants are per packet with round-robin fairness.
//               The grant is held until the packet's last word has been sent.
//               Each word is serialized MSB byte first over the
//               start/data/done handshake of the transmitter.
// Ports       : i_clk, i_reset            clock, synchronous active-high reset
//               i_reqN_valid/data/last    requester N word stream (N = 0, 1)
//               o_reqN_ready              word accepted when valid & ready
//               i_uart_tx_done            transmitter idle level
//               o_uart_tx_start/data      byte request to the transmitter
//               o_grant                   one-hot owner (01 req0, 10 req1)
//               o_busy                    arbiter is not idle
// Notes       : BITS_SIZE must be an integer multiple of SIZE_TRAMA.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int BITS_SIZE  = 32,
    parameter int SIZE_TRAMA = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req0_valid,
    input  logic [BITS_SIZE-1:0]  i_req0_data,
    input  logic                  i_req0_last,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic [BITS_SIZE-1:0]  i_req1_data,
    input  logic                  i_req1_last,
    output logic                  o_req1_ready,
    input  logic                  i_uart_tx_done,
    output logic                  o_uart_tx_start,
    output logic [SIZE_TRAMA-1:0] o_uart_tx_data,
    output logic [1:0]            o_grant,
    output logic                  o_busy
);

    localparam int N_BYTES = BITS_SIZE / SIZE_TRAMA;
    localparam int c_CNT_W = $clog2(N_BYTES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(N_BYTES);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [BITS_SIZE-1:0]  r_shift;
    logic                  r_last;
    logic                  r_rr;        // 1: req1 preferred on a tie
    logic [1:0]            r_grant;
    logic                  r_tx_start;
    logic [SIZE_TRAMA-1:0] r_tx_data;

    logic                  w_any_valid;
    logic                  w_pick1;
    logic                  w_sel_valid;
    logic [BITS_SIZE-1:0]  w_sel_data;
    logic                  w_sel_last;
    logic                  w_accept;
    logic                  w_more_bytes;
    logic [BITS_SIZE-1:0]  w_shift_next;
    logic                  w_tx_start_next;
    logic [SIZE_TRAMA-1:0] w_tx_data_next;
    logic [1:0]            w_grant_next;

    assign w_any_valid  = i_req0_valid | i_req1_valid;
    // req1 wins when it is the only one asking, or on a tie when it is next in turn
    assign w_pick1      = i_req1_valid & (~i_req0_valid | r_rr);
    assign w_sel_valid  = (r_grant[0] & i_req0_valid) | (r_grant[1] & i_req1_valid);
    assign w_sel_data   = r_grant[1] ? i_req1_data : i_req0_data;
    assign w_sel_last   = r_grant[1] ? i_req1_last : i_req0_last;
    // A word is only taken while the transmitter is idle, so SEND never
    // starts against a frame that is still in flight.
    assign w_accept     = (r_state == c_ST_LOAD) & i_uart_tx_done & w_sel_valid;
    assign w_more_bytes = (r_cnt < c_CNT_FULL);
    assign w_shift_next = r_shift << SIZE_TRAMA;

    assign o_uart_tx_start = r_tx_start;
    assign o_uart_tx_data  = r_tx_data;
    assign o_grant         = r_grant;
    assign o_busy          = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= c_ST_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_grant    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= w_tx_start_next;
            r_tx_data  <= w_tx_data_next;
            r_grant    <= w_grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Word datapath: shift register, byte counter, last flag, rr pointer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_last  <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_shift <= w_sel_data;
                        r_last  <= w_sel_last;
                        r_cnt   <= '0;
                    end
                end
                c_ST_SEND: begin
                    if (!i_uart_tx_done) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_WAIT: begin
                    if (i_uart_tx_done) begin
                        if (w_more_bytes) begin
                            r_shift <= w_shift_next;
                        end else if (r_last) begin
                            // Served req0 -> req1 is next in turn, and vice versa
                            r_rr <= r_grant[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (w_accept) begin
                    w_state_next = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                // The transmitter dropping done is the acknowledge of start
                if (!i_uart_tx_done) begin
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (i_uart_tx_done) begin
                    if (w_more_bytes) begin
                        w_state_next = c_ST_SEND;
                    end else if (r_last) begin
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_state_next = c_ST_LOAD;
                    end
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: ready strobes and next values of registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_start_next = 1'b0;
        w_tx_data_next  = r_tx_data;
        w_grant_next    = r_grant;
        o_req0_ready    = 1'b0;
        o_req1_ready    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_valid) begin
                    w_grant_next = w_pick1 ? 2'b10 : 2'b01;
                end
            end
            c_ST_LOAD: begin
                o_req0_ready = r_grant[0] & i_uart_tx_done;
                o_req1_ready = r_grant[1] & i_uart_tx_done;
                if (w_accept) begin
                    w_tx_start_next = 1'b1;
                    w_tx_data_next  = w_sel_data[BITS_SIZE-1 -: SIZE_TRAMA];
                end
            end
            c_ST_SEND: begin
                // Hold start until the transmitter reports it has begun
                w_tx_start_next = i_uart_tx_done;
            end
            c_ST_WAIT: begin
                if (i_uart_tx_done) begin
                    if (w_more_bytes) begin
                        w_tx_start_next = 1'b1;
                        w_tx_data_next  = w_shift_next[BITS_SIZE-1 -: SIZE_TRAMA];
                    end else if (r_last) begin
                        w_grant_next = 2'b00;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Requesters replay
//               queued packets, a transmitter model acknowledges bytes, and a
//               byte-level reference model predicts the serialized stream,
//               packet ownership and round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [7:0]  gap;    // idle cycles before this word is presented
    } word_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        req0_valid, req0_last, req1_valid, req1_last;
    logic [31:0] req0_data, req1_data;
    logic        o_req0_ready, o_req1_ready;
    logic        tx_done;
    logic        o_uart_tx_start;
    logic [7:0]  o_uart_tx_data;
    logic [1:0]  o_grant;
    logic        o_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.BITS_SIZE(32), .SIZE_TRAMA(8)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req0_valid(req0_valid), .i_req0_data(req0_data), .i_req0_last(req0_last),
        .o_req0_ready(o_req0_ready),
        .i_req1_valid(req1_valid), .i_req1_data(req1_data), .i_req1_last(req1_last),
        .o_req1_ready(o_req1_ready),
        .i_uart_tx_done(tx_done), .o_uart_tx_start(o_uart_tx_start),
        .o_uart_tx_data(o_uart_tx_data), .o_grant(o_grant), .o_busy(o_busy)
    );

    word_t      q0[$];
    word_t      q1[$];
    logic [7:0] exp_q[$];
    logic [7:0] cap_log[$];
    int         order[$];
    int         n_tests, n_fail;
    int         cycle, caps, rises;
    int         waitc[2], pend[2], hs_cnt[2];
    bit         pkt_start[2], hs[2];
    int         cur_owner, grant_owner, rr_m, last_accept;
    int         tx_cnt, tx_len, tx_hold;
    logic       prev_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    function automatic bit q_empty(input int r);
        return (r == 0) ? (q0.size() == 0) : (q1.size() == 0);
    endfunction

    function automatic word_t q_front(input int r);
        return (r == 0) ? q0[0] : q1[0];
    endfunction

    task automatic push_word(input int r, input logic [31:0] w, input bit last, input int gap);
        word_t e;
        e.w = w; e.last = last; e.gap = 8'(gap);
        if (q_empty(r)) waitc[r] = gap;
        if (r == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Reference model: an accepted word queues its four bytes MSB first and
    // updates packet ownership and the round-robin turn.
    task automatic accept_word(input int r);
        word_t e;
        e = q_front(r);
        if (r == 0) q0.delete(0); else q1.delete(0);
        hs_cnt[r]++;
        if (cur_owner < 0) begin
            check("prev_packet_drained", exp_q.size(), 0);
            // The other requester was already waiting at arbitration time:
            // the winner must be the one whose turn it is.
            if (pend[1-r] >= 0 && pend[1-r] <= last_accept) check("arb_turn", r, rr_m);
            cur_owner = r; grant_owner = r; order.push_back(r); pend[r] = -1;
        end else begin
            check("hs_owner", r, cur_owner);
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(e.w[31-8*b -: 8]);
        pkt_start[r] = e.last;
        if (e.last) begin
            rr_m = 1 - r; cur_owner = -1; last_accept = cycle;
        end
        if (!q_empty(r)) waitc[r] = int'(q_front(r).gap);
    endtask

    task automatic tx_model();
        logic [31:0] want;
        if (o_uart_tx_start && !prev_start) rises++;
        prev_start = o_uart_tx_start;
        if (tx_hold > 0) begin
            tx_hold--; tx_done = 1'b0;
        end else if (tx_done && o_uart_tx_start) begin
            caps++;
            cap_log.push_back(o_uart_tx_data);
            if (exp_q.size() > 0) want = {24'h0, exp_q.pop_front()};
            else                  want = 32'h100;   // no byte was owed
            check("tx_byte", {24'h0, o_uart_tx_data}, want);
            if (exp_q.size() == 0 && cur_owner < 0) grant_owner = -1;
            tx_done = 1'b0;
            tx_cnt  = (tx_len == 0) ? int'($urandom_range(1, 6)) : tx_len;
        end else if (!tx_done) begin
            if (tx_cnt > 0) tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
    endtask

    task automatic monitor();
        check("ready_exclusive", {31'h0, o_req0_ready & o_req1_ready}, 0);
        if (grant_owner >= 0) begin
            check("grant_held", {30'h0, o_grant}, (grant_owner == 0) ? 32'd1 : 32'd2);
            check("busy_in_packet", {31'h0, o_busy}, 1);
            check("ready_non_owner", {31'h0, (grant_owner == 0) ? o_req1_ready : o_req0_ready}, 0);
        end
        if (tx_hold > 0) begin
            check("hold_no_start", {31'h0, o_uart_tx_start}, 0);
            check("hold_no_ready", {31'h0, o_req0_ready | o_req1_ready}, 0);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            bit    v;
            word_t e;
            v = !q_empty(r) && waitc[r] == 0;
            if (!q_empty(r) && waitc[r] > 0) waitc[r]--;
            if (v && pkt_start[r] && pend[r] < 0) pend[r] = cycle;
            if (v) e = q_front(r);
            else begin e.w = $urandom; e.last = 1'b0; e.gap = 8'h0; end
            if (r == 0) begin req0_valid = v; req0_data = e.w; req0_last = e.last; end
            else        begin req1_valid = v; req1_data = e.w; req1_last = e.last; end
        end
    endtask

    task automatic step();
        bit rst_edge;
        rst_edge = i_reset;
        @(posedge clk);
        #1;
        cycle++;
        if (rst_edge) begin
            exp_q.delete();
            cur_owner = -1; grant_owner = -1; rr_m = 0; last_accept = cycle;
        end else begin
            for (int r = 0; r < 2; r++) if (hs[r]) accept_word(r);
        end
        tx_model();
        #1;
        monitor();
        drive();
        #1;
        hs[0] = req0_valid & o_req0_ready;
        hs[1] = req1_valid & o_req1_ready;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || cur_owner >= 0)
               && n < max_cycles) begin
            step(); n++;
        end
        check("drain_in_time", {31'h0, n < max_cycles}, 1);
        repeat (16) step();
        check("idle_busy", {31'h0, o_busy}, 0);
        check("idle_grant", {30'h0, o_grant}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, h0, o0;
        logic [31:0] w;
        n_tests = 0; n_fail = 0; cycle = 0; caps = 0; rises = 0;
        cur_owner = -1; grant_owner = -1; rr_m = 0; last_accept = 0;
        tx_cnt = 0; tx_len = 10; tx_hold = 0; prev_start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            waitc[r] = 0; pend[r] = -1; hs_cnt[r] = 0; pkt_start[r] = 1'b1; hs[r] = 1'b0;
        end
        i_reset = 1'b1; tx_done = 1'b1;
        req0_valid = 0; req0_data = 0; req0_last = 0;
        req1_valid = 0; req1_data = 0; req1_last = 0;

        repeat (3) step();
        check("rst_start", {31'h0, o_uart_tx_start}, 0);
        check("rst_data",  {24'h0, o_uart_tx_data}, 0);
        check("rst_grant", {30'h0, o_grant}, 0);
        check("rst_busy",  {31'h0, o_busy}, 0);
        check("rst_ready0", {31'h0, o_req0_ready}, 0);
        check("rst_ready1", {31'h0, o_req1_ready}, 0);
        i_reset = 1'b0;
        repeat (2) step();

        // Single word from req0
        c0 = caps; r0 = rises; h0 = hs_cnt[0];
        push_word(0, 32'h12345678, 1'b1, 0);
        run_until_idle(400);
        check("single_bytes",  caps - c0, 4);
        check("single_starts", rises - r0, 4);
        check("single_ready",  hs_cnt[0] - h0, 1);
        w = 32'h12345678;
        for (int b = 0; b < 4; b++) check("single_order", {24'h0, cap_log[c0+b]}, {24'h0, w[31-8*b -: 8]});

        // Fairness: both valid through reset, then a second simultaneous request
        i_reset = 1'b1;
        o0 = order.size(); c0 = caps;
        push_word(0, 32'hAAAA0001, 1'b0, 0); push_word(0, 32'hAAAA0002, 1'b1, 0);
        push_word(1, 32'hBBBB0001, 1'b0, 0); push_word(1, 32'hBBBB0002, 1'b1, 0);
        repeat (3) step();
        i_reset = 1'b0;
        run_until_idle(800);
        push_word(0, 32'hAAAA0003, 1'b1, 0);
        push_word(1, 32'hBBBB0003, 1'b1, 0);
        run_until_idle(800);
        check("fair_first",  order[o0], 0);
        check("fair_second", order[o0+1], 1);
        check("fair_third",  order[o0+2], 0);
        check("fair_byte0",  {24'h0, cap_log[c0]}, 32'hAA);
        check("fair_byte8",  {24'h0, cap_log[c0+8]}, 32'hBB);

        // Lock: 20-cycle gap inside a req0 packet while req1 waits
        o0 = order.size();
        push_word(0, 32'h11110001, 1'b0, 0);
        push_word(0, 32'h11110002, 1'b1, 20);
        push_word(1, 32'h22220001, 1'b1, 3);
        run_until_idle(800);
        check("lock_first",  order[o0], 0);
        check("lock_second", order[o0+1], 1);

        // Busy transmitter when req1 becomes valid
        c0 = caps;
        tx_hold = 15;
        push_word(1, 32'h5A5AA5A5, 1'b1, 0);
        run_until_idle(400);
        check("busytx_bytes", caps - c0, 4);

        // Reset after two bytes of a word
        c0 = caps;
        push_word(0, 32'hCAFEF00D, 1'b1, 0);
        for (int n = 0; n < 300 && caps - c0 < 2; n++) step();
        check("rst_mid_reach", caps - c0, 2);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("rst_mid_start", {31'h0, o_uart_tx_start}, 0);
        check("rst_mid_grant", {30'h0, o_grant}, 0);
        check("rst_mid_busy",  {31'h0, o_busy}, 0);
        repeat (30) step();
        check("rst_mid_abort", caps - c0, 2);
        c0 = caps;
        push_word(1, 32'h00000001, 1'b1, 0);
        run_until_idle(400);
        w = 32'h00000001;
        for (int b = 0; b < 4; b++) check("post_rst_order", {24'h0, cap_log[c0+b]}, {24'h0, w[31-8*b -: 8]});

        // Debug dump: 50-word packet
        tx_len = 2;
        c0 = caps; h0 = hs_cnt[0]; o0 = order.size();
        push_word(0, 32'h0000_0100, 1'b0, 0);
        push_word(0, 32'h0001_2345, 1'b0, 0);
        for (int i = 0; i < 48; i++) push_word(0, $urandom, (i == 47), 0);
        run_until_idle(5000);
        check("dump_bytes",   caps - c0, 200);
        check("dump_words",   hs_cnt[0] - h0, 50);
        check("dump_packets", order.size() - o0, 1);

        // Randomized traffic with random transmitter latency
        tx_len = 0;
        for (int k = 0; k < 24; k++) begin
            int r, len;
            r   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++)
                push_word(r, $urandom, (i == len - 1),
                          (i == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 3)));
        end
        run_until_idle(20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
